bcd_countdown_counter: RTL and testbench
========================================

Name: bcd_countdown_counter

Overview:
Multi-digit BCD down-counter for countdown values on the seven-segment displays, such as the game timer and remaining lives.
It is the decrementing counterpart of the score up-counter: it loads a BCD value, then decrements by one per accepted enable, rippling borrows one digit per clock.
Its countValue bus feeds the existing N-digit hex-to-7-segment converter. Its zero/expired outputs feed game-control logic.

Parameters:
COUNTER_DIGITS, 6, number of BCD digits (1..8)
COUNTER_BITWIDTH, 4*COUNTER_DIGITS, width of countValue/loadValue (derived; do not override)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
load  input  1  load request; sampled only while ready=1
loadValue  input  COUNTER_BITWIDTH  BCD value to load; digit 0 in bits [3:0]
enable  input  1  decrement request; sampled only while ready=1
ready  output  1  1 = idle, accepts load/enable, countValue valid
countValue  output  COUNTER_BITWIDTH  current BCD count, registered
zero  output  1  registered; 1 when ready=1 and countValue==0
expired  output  1  one-cycle pulse when a decrement reaches 0

Behaviour:
- Reset (reset=0, asynchronous):
  - countValue=0, ready=1, zero=1, expired=0, state=IDLE, digit index=0.
  - Takes effect immediately, including mid-ripple.
  - After reset deasserts, operation resumes at the first rising edge.
- States: IDLE, RIPPLE. Digit index register width is ceil(log2(COUNTER_DIGITS)), minimum 1.
- IDLE (ready=1):
  - load=1: on that edge, countValue <= loadValue. Any digit >9 clamps to 9. State stays IDLE. zero and expired are not touched this edge; zero reflects the new value next cycle.
  - load=1 and enable=1 together: load wins, enable is dropped.
  - enable=1, load=0, countValue!=0: go to RIPPLE, index<=0, ready<=0.
  - enable=1 with countValue==0: ignored. Count saturates at 0, no expired pulse.
- RIPPLE (ready=0), one digit per cycle:
  - digit[index]!=0: digit[index] <= digit[index]-1, go to IDLE, ready<=1, zero updated.
    - If the resulting count is 0, expired<=1 for exactly one cycle.
  - digit[index]==0: digit[index] <= 9, index<=index+1, stay in RIPPLE.
  - Entry requires a nonzero count, so a nonzero digit is always found by index COUNTER_DIGITS-1. No wrap-around is possible.
  - load and enable are ignored in RIPPLE. They are not queued.
- Latency: k trailing zero digits give ready low for k+1 cycles.
  - Example 000005: 1 cycle.
  - Example 001000: 4 cycles, ending at 000999.
- countValue is only guaranteed valid when ready=1. Intermediate digits (partially 9-filled) are visible during RIPPLE.
- zero is registered and updated on load completion, decrement completion and reset. It is 0 during RIPPLE.
- expired is 0 in every cycle other than the completing cycle.

Test Plan:
1. Reset, then idle -> countValue=000000, zero=1, ready=1, expired=0. Then enable pulse -> no state change, ready stays 1, expired stays 0.
2. load 000005, then enable -> ready low 1 cycle, countValue=000004, zero=0. Four more enables -> 000000, zero=1, expired pulses once on the last enable only.
3. load 001000, then enable -> ready low exactly 4 cycles, final countValue=000999. A load/enable asserted during those cycles has no effect.
4. load 0A00F3 (invalid digits) -> countValue=090093. Load and enable asserted together with 000123 -> countValue=000123, no decrement.
5. load 100000, enable, then drive reset=0 on the 3rd RIPPLE cycle -> immediately countValue=000000, ready=1, zero=1. After release, load 000002 and two enables work normally, expired pulses on reaching 000000.
6. COUNTER_DIGITS=1: load 9, apply 9 enables -> counts 8..0, ready low 1 cycle each, expired once, then saturates at 0.

Source files
------------

// File: rtl/bcd_countdown_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_countdown_counter_if : load/decrement request and count status bus   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface bcd_countdown_counter_if #(
  parameter int COUNTER_DIGITS = 6
);
  localparam int COUNTER_BITWIDTH = 4 * COUNTER_DIGITS;

  logic                        load;
  logic [COUNTER_BITWIDTH-1:0] loadValue;
  logic                        enable;
  logic                        ready;
  logic [COUNTER_BITWIDTH-1:0] countValue;
  logic                        zero;
  logic                        expired;

  modport master (
    output load, loadValue, enable,
    input  ready, countValue, zero, expired
  );

  modport slave (
    input  load, loadValue, enable,
    output ready, countValue, zero, expired
  );
endinterface
`default_nettype wire

// File: rtl/bcd_countdown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_countdown_counter : multi-digit BCD down-counter, one borrow/clock   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bcd_countdown_counter #(
  parameter int COUNTER_DIGITS = 6
) (
  input  wire logic               clock,
  input  wire logic               reset,
  bcd_countdown_counter_if.slave  bus
);
  localparam int COUNTER_BITWIDTH = 4 * COUNTER_DIGITS;
  localparam int IDX_W            = (COUNTER_DIGITS > 1) ? $clog2(COUNTER_DIGITS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RIPPLE = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [COUNTER_BITWIDTH-1:0] count_q, count_d;
  logic [IDX_W-1:0]            idx_q,   idx_d;
  logic                        ready_q, ready_d;
  logic                        zero_q,  zero_d;
  logic                        expired_q, expired_d;

  logic [COUNTER_BITWIDTH-1:0] w_load_clamped;
  logic [3:0]                  w_cur_digit;

  // Out-of-range BCD digits on load saturate to 9.
  for (genvar g = 0; g < COUNTER_DIGITS; g++) begin : g_clamp
    assign w_load_clamped[4*g +: 4] =
      (bus.loadValue[4*g +: 4] > 4'd9) ? 4'd9 : bus.loadValue[4*g +: 4];
  end

  assign w_cur_digit = count_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    zero_d    = zero_q;
    expired_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        zero_d  = (count_q == '0);
        if (bus.load) begin
          // zero catches up with the loaded value on the following edge
          count_d = w_load_clamped;
          zero_d  = zero_q;
        end else if (bus.enable && (count_q != '0)) begin
          state_d = ST_RIPPLE;
          idx_d   = '0;
          ready_d = 1'b0;
          zero_d  = 1'b0;
        end
      end

      ST_RIPPLE: begin
        if (w_cur_digit != 4'd0) begin
          count_d[{idx_q, 2'b00} +: 4] = w_cur_digit - 4'd1;
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          zero_d    = (count_d == '0);
          expired_d = zero_d;
        end else begin
          count_d[{idx_q, 2'b00} +: 4] = 4'd9;
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b1;
      zero_q    <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      zero_q    <= zero_d;
      expired_q <= expired_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.countValue = count_q;
  assign bus.zero       = zero_q;
  assign bus.expired    = expired_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_countdown_counter : random + directed bench with decimal model    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_bcd_countdown_counter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bcd_countdown_counter_if #(.COUNTER_DIGITS(6)) bus6 ();
  bcd_countdown_counter_if #(.COUNTER_DIGITS(1)) bus1 ();

  bcd_countdown_counter #(.COUNTER_DIGITS(6)) dut6 (.clock(clock), .reset(reset), .bus(bus6));
  bcd_countdown_counter #(.COUNTER_DIGITS(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;   // decimal value the 6-digit counter should hold

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_val(input logic [31:0] v, input int nd);
    int sum = 0;
    int p   = 1;
    for (int i = 0; i < nd; i++) begin
      int d = int'((v >> (4*i)) & 32'hF);
      if (d > 9) d = 9;
      sum += d * p;
      p   *= 10;
    end
    return sum;
  endfunction

  function automatic logic [31:0] to_bcd(input int n, input int nd);
    logic [31:0] r = '0;
    int          m = n;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int trailing_zeros(input int n);
    int k = 0;
    int m = n;
    while (m != 0 && (m % 10) == 0) begin
      k++;
      m = m / 10;
    end
    return k;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load6(input logic [23:0] v);
    bus6.load      = 1'b1;
    bus6.loadValue = v;
    tick();
    bus6.load = 1'b0;
    model = clamp_val({8'h0, v}, 6);
    check("load_value",   {8'h0, bus6.countValue}, to_bcd(model, 6));
    check("load_ready",   {31'h0, bus6.ready},   32'd1);
    check("load_expired", {31'h0, bus6.expired}, 32'd0);
    tick();
    check("load_zero",    {31'h0, bus6.zero}, (model == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_enable6(input bit noise);
    int lat;
    int exp_lat;
    bit hit0;
    exp_lat = (model == 0) ? 0 : trailing_zeros(model) + 1;
    bus6.enable = 1'b1;
    tick();
    bus6.enable = 1'b0;
    lat = 0;
    while (bus6.ready !== 1'b1 && lat < 20) begin
      check("rip_expired", {31'h0, bus6.expired}, 32'd0);
      check("rip_zero",    {31'h0, bus6.zero},    32'd0);
      if (noise) begin
        bus6.load      = 1'($urandom);
        bus6.enable    = 1'($urandom);
        bus6.loadValue = 24'($urandom);
      end
      tick();
      lat++;
    end
    bus6.load   = 1'b0;
    bus6.enable = 1'b0;
    check("latency", lat, exp_lat);
    hit0 = (model != 0) && (model == 1);
    if (model > 0) model--;
    check("dec_value",   {8'h0, bus6.countValue}, to_bcd(model, 6));
    check("dec_ready",   {31'h0, bus6.ready},   32'd1);
    check("dec_zero",    {31'h0, bus6.zero},    (model == 0) ? 32'd1 : 32'd0);
    check("dec_expired", {31'h0, bus6.expired}, {31'h0, hit0});
    tick();
    check("expired_pulse", {31'h0, bus6.expired}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] rv;
    int          n_exp1;

    bus6.load = 1'b0; bus6.enable = 1'b0; bus6.loadValue = '0;
    bus1.load = 1'b0; bus1.enable = 1'b0; bus1.loadValue = '0;

    // 1: reset state, then enable at zero is ignored
    repeat (3) @(posedge clock);
    #1;
    check("rst_value",   {8'h0, bus6.countValue}, 32'd0);
    check("rst_ready",   {31'h0, bus6.ready},   32'd1);
    check("rst_zero",    {31'h0, bus6.zero},    32'd1);
    check("rst_expired", {31'h0, bus6.expired}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("idle_value", {8'h0, bus6.countValue}, 32'd0);
    check("idle_zero",  {31'h0, bus6.zero},    32'd1);
    model = 0;
    do_enable6(1'b0);

    // 2: count 5 down to 0
    do_load6(24'h000005);
    repeat (5) do_enable6(1'b0);

    // 3: multi-digit borrow with ignored requests during the ripple
    do_load6(24'h001000);
    do_enable6(1'b1);

    // 4: clamping and load priority over enable
    do_load6(24'h0A00F3);
    check("clamp_value", {8'h0, bus6.countValue}, 32'h00090093);
    bus6.load = 1'b1; bus6.enable = 1'b1; bus6.loadValue = 24'h000123;
    tick();
    bus6.load = 1'b0; bus6.enable = 1'b0;
    model = 123;
    check("ld_en_value", {8'h0, bus6.countValue}, 32'h00000123);
    check("ld_en_ready", {31'h0, bus6.ready},   32'd1);
    tick();
    check("ld_en_hold",  {8'h0, bus6.countValue}, 32'h00000123);
    check("ld_en_ready2", {31'h0, bus6.ready},  32'd1);

    // 5: asynchronous reset in the 3rd ripple cycle
    do_load6(24'h100000);
    bus6.enable = 1'b1;
    tick();
    bus6.enable = 1'b0;
    tick();
    tick();
    check("mid_rip_ready", {31'h0, bus6.ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("arst_value", {8'h0, bus6.countValue}, 32'd0);
    check("arst_ready", {31'h0, bus6.ready},   32'd1);
    check("arst_zero",  {31'h0, bus6.zero},    32'd1);
    @(negedge clock);
    reset = 1'b1;
    model = 0;
    do_load6(24'h000002);
    do_enable6(1'b0);
    do_enable6(1'b0);

    // randomized loads and decrements against the decimal model
    for (int op = 0; op < 80; op++) begin
      if (($urandom % 4) == 0) begin
        for (int i = 0; i < 6; i++)
          rv[4*i +: 4] = (($urandom % 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2) == 0 ? 1 : 0);
        do_load6(rv);
      end else begin
        do_enable6(1'($urandom));
      end
    end

    // 6: single-digit instance
    bus1.load = 1'b1; bus1.loadValue = 4'h9;
    tick();
    bus1.load = 1'b0;
    check("d1_load", {28'h0, bus1.countValue}, 32'd9);
    tick();
    n_exp1 = 0;
    for (int n = 8; n >= 0; n--) begin
      bus1.enable = 1'b1;
      tick();
      bus1.enable = 1'b0;
      check("d1_busy", {31'h0, bus1.ready}, 32'd0);
      tick();
      check("d1_ready", {31'h0, bus1.ready}, 32'd1);
      check("d1_value", {28'h0, bus1.countValue}, n);
      if (bus1.expired === 1'b1) n_exp1++;
      check("d1_expired", {31'h0, bus1.expired}, (n == 0) ? 32'd1 : 32'd0);
      tick();
    end
    check("d1_expired_count", n_exp1, 1);
    bus1.enable = 1'b1;
    tick();
    bus1.enable = 1'b0;
    check("d1_sat_ready",   {31'h0, bus1.ready},   32'd1);
    check("d1_sat_value",   {28'h0, bus1.countValue}, 32'd0);
    check("d1_sat_expired", {31'h0, bus1.expired}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
